// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin multi-channel HC-SR04 ranger: one sensor at a time, echo width to mm without a divider.
// Define ULTRASONIC_AVG_EN to report a per-channel (3*prev + new)/4 running average instead of raw mm.
module ultrasonic_ranger_mc #(
    parameter int CLK_HZ       = 50000000,
    parameter int NUM_CH       = 4,
    parameter int DIST_W       = 16,
    parameter int TRIG_US      = 10,
    parameter int ECHO_WAIT_US = 30000,
    parameter int MAX_ECHO_US  = 25000,
    parameter int PERIOD_US    = 60000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trigger,
    output logic [DIST_W-1:0] distance,
    output logic [CH_W-1:0]   dist_ch,
    output logic              valid,
    output logic              timeout,
    output logic              busy
);
    localparam int CYC_US     = CLK_HZ / 1000000;
    localparam int CYC_PER_MM = (2 * CLK_HZ + 171500) / 343000;
    localparam int TRIG_CYC   = TRIG_US * CYC_US;
    localparam int WAIT_CYC   = ECHO_WAIT_US * CYC_US;
    localparam int MAX_CYC    = MAX_ECHO_US * CYC_US;
    localparam int PERIOD_CYC = PERIOD_US * CYC_US;
    localparam int T_MAX1     = (TRIG_CYC > WAIT_CYC) ? TRIG_CYC : WAIT_CYC;
    localparam int T_MAX2     = (MAX_CYC > PERIOD_CYC) ? MAX_CYC : PERIOD_CYC;
    localparam int T_MAX      = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
    localparam int TMR_W      = $clog2(T_MAX + 1);
    localparam int PRE_W      = (CYC_PER_MM > 1) ? $clog2(CYC_PER_MM) : 1;

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_REPORT, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, ch_next;
    logic [TMR_W-1:0]  timer_q, timer_d, period_q, period_d;
    logic [PRE_W-1:0]  presc_q, presc_d, step_presc, cnt_presc;
    logic [DIST_W-1:0] mm_q, mm_d, step_mm, cnt_mm;
    logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, trigger_q, trigger_d;
    logic              sel_echo, sel_prev_q, sel_prev_d, echo_rise;
    logic [DIST_W-1:0] distance_q, distance_d, rep_mm, rep_out;
    logic [CH_W-1:0]   dist_ch_q, dist_ch_d;
    logic              valid_q, valid_d, timeout_q, timeout_d, busy_q, busy_d;
    logic              rep_go, rep_to;
`ifdef ULTRASONIC_AVG_EN
    logic [DIST_W-1:0] avg_q [NUM_CH];
    logic [DIST_W-1:0] avg_d [NUM_CH];
    logic [NUM_CH-1:0] seen_q, seen_d;
    logic [DIST_W+1:0] blend;
`endif

    always_comb begin
        sync1_d    = echo;
        sync2_d    = sync1_q;
        sel_echo   = sync2_q[ch_q];
        sel_prev_d = sel_echo;
        echo_rise  = sel_echo & ~sel_prev_q;
        ch_next    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

        // The cycle that recognises the echo rise is itself counted, so MEASURE
        // entry steps the prescaler from zero instead of from the held values.
        step_presc = (state_q == S_MEAS) ? presc_q : '0;
        step_mm    = (state_q == S_MEAS) ? mm_q : '0;
        if (step_presc == PRE_W'(CYC_PER_MM - 1)) begin
            cnt_presc = '0;
            cnt_mm    = (&step_mm) ? step_mm : step_mm + 1'b1;
        end else begin
            cnt_presc = step_presc + 1'b1;
            cnt_mm    = step_mm;
        end

        state_d    = state_q;
        ch_d       = ch_q;
        timer_d    = timer_q;
        period_d   = period_q;
        presc_d    = presc_q;
        mm_d       = mm_q;
        trigger_d  = trigger_q;
        distance_d = distance_q;
        dist_ch_d  = dist_ch_q;
        timeout_d  = timeout_q;
        valid_d    = 1'b0;
        rep_go     = 1'b0;
        rep_to     = 1'b0;
        rep_mm     = mm_q;

        if (state_q != S_IDLE && period_q != TMR_W'(PERIOD_CYC))
            period_d = period_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d         = S_TRIG;
                    timer_d         = '0;
                    period_d        = '0;
                    trigger_d       = '0;
                    trigger_d[ch_q] = 1'b1;
                end
            end
            S_TRIG: begin
                if (timer_q == TMR_W'(TRIG_CYC - 1)) begin
                    state_d   = S_WAIT;
                    timer_d   = '0;
                    trigger_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (echo_rise) begin
                    state_d = S_MEAS;
                    timer_d = TMR_W'(1);
                    presc_d = cnt_presc;
                    mm_d    = cnt_mm;
                end else if (timer_q == TMR_W'(WAIT_CYC - 1)) begin
                    rep_go = 1'b1;
                    rep_to = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_MEAS: begin
                // A fall on the same cycle as the limit still reports a distance.
                if (!sel_echo) begin
                    rep_go = 1'b1;
                end else if (timer_q == TMR_W'(MAX_CYC)) begin
                    rep_go = 1'b1;
                    rep_to = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                    presc_d = cnt_presc;
                    mm_d    = cnt_mm;
                end
            end
            S_REPORT: state_d = S_HOLD;
            S_HOLD: begin
                if (period_q >= TMR_W'(PERIOD_CYC - 1)) begin
                    ch_d = ch_next;
                    if (enable) begin
                        state_d            = S_TRIG;
                        timer_d            = '0;
                        period_d           = '0;
                        trigger_d          = '0;
                        trigger_d[ch_next] = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rep_out = rep_mm;
`ifdef ULTRASONIC_AVG_EN
        avg_d  = avg_q;
        seen_d = seen_q;
        blend  = ({2'b00, avg_q[ch_q]} + {1'b0, avg_q[ch_q], 1'b0} + {2'b00, rep_mm}) >> 2;
        if (seen_q[ch_q])
            rep_out = blend[DIST_W-1:0];
        if (rep_go && !rep_to) begin
            avg_d[ch_q]  = rep_out;
            seen_d[ch_q] = 1'b1;
        end
`endif

        if (rep_go) begin
            state_d    = S_REPORT;
            valid_d    = 1'b1;
            dist_ch_d  = ch_q;
            timeout_d  = rep_to;
            distance_d = rep_to ? '1 : rep_out;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            timer_q    <= '0;
            period_q   <= '0;
            presc_q    <= '0;
            mm_q       <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sel_prev_q <= 1'b0;
            trigger_q  <= '0;
            distance_q <= '0;
            dist_ch_q  <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ULTRASONIC_AVG_EN
            for (int i = 0; i < NUM_CH; i++) avg_q[i] <= '0;
            seen_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            timer_q    <= timer_d;
            period_q   <= period_d;
            presc_q    <= presc_d;
            mm_q       <= mm_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sel_prev_q <= sel_prev_d;
            trigger_q  <= trigger_d;
            distance_q <= distance_d;
            dist_ch_q  <= dist_ch_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
`ifdef ULTRASONIC_AVG_EN
            avg_q  <= avg_d;
            seen_q <= seen_d;
`endif
        end
    end

    assign trigger  = trigger_q;
    assign distance = distance_q;
    assign dist_ch  = dist_ch_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
    assign busy     = busy_q;
endmodule

// File: doc/ultrasonic_ranger_mc.md
Name: ultrasonic_ranger_mc

Overview:
Parametrised multi-channel successor to the single-sensor HC-SR04 ranger. Drives NUM_CH ultrasonic sensors round-robin, one at a time to avoid acoustic crosstalk. Converts each echo pulse to millimetres without a divider, flags no-echo and over-range timeouts, and presents one result per measurement on a valid-pulse interface to the game logic.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
NUM_CH, 4, number of sensors (1..8)
DIST_W, 16, distance output width in bits
TRIG_US, 10, trigger pulse width in us
ECHO_WAIT_US, 30000, max wait from trigger fall to echo rise
MAX_ECHO_US, 25000, max echo-high time; longer is over-range
PERIOD_US, 60000, min time from one trigger rise to the next (any channel)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = free-run measurement cycle; 0 = stop after current measurement
echo  in  NUM_CH  raw async echo inputs, one per sensor
trigger  out  NUM_CH  trigger outputs, at most one bit high at any time
distance  out  DIST_W  result in mm; valid while valid=1, held after
dist_ch  out  clog2(NUM_CH) (min 1)  channel index of distance
valid  out  1  one-cycle pulse per completed measurement
timeout  out  1  qualifies valid: 1 = no echo or over-range
busy  out  1  1 whenever FSM not in IDLE

Behaviour:
- Reset (reset=0 at clk edge): trigger=0, distance=0, dist_ch=0, valid=0, timeout=0, busy=0, FSM=IDLE, channel pointer=0, all counters 0, sync flops 0. Reset mid-measurement aborts immediately; trigger falls on that edge.
- Echo sync: each echo bit goes through 2-flop synchroniser; FSM sees only the synchronised bit of the current channel. Echo-rise to FSM recognition = 2 cycles.
- Timebase: localparam CYC_US = CLK_HZ/1000000; all *_US limits counted in cycles (value*CYC_US).
- Distance: localparam CYC_PER_MM = (2*CLK_HZ + 171500)/343000 (round-trip per mm at 343 m/s, rounded). While echo high, prescaler counts cycles; every CYC_PER_MM cycles mm counter increments, saturating at 2^DIST_W-1.
- FSM states and transitions:
  IDLE: busy=0; if enable=1 -> TRIG, clear timers.
  TRIG: trigger[ch]=1 for TRIG_US*CYC_US cycles -> WAIT_ECHO.
  WAIT_ECHO: if sync echo=1 -> MEASURE (mm counter cleared); if ECHO_WAIT_US elapsed -> REPORT with timeout=1, distance=all-ones.
  MEASURE: count while echo=1; echo falls -> REPORT with timeout=0, distance=mm count; if MAX_ECHO_US elapsed with echo still high -> REPORT with timeout=1, distance=all-ones.
  REPORT: valid=1 for exactly this cycle, dist_ch=ch -> HOLDOFF.
  HOLDOFF: wait until PERIOD_US*CYC_US cycles since trigger rise (period counter runs from TRIG entry); then ch = ch+1, wrapping NUM_CH-1 -> 0; -> TRIG if enable=1 else IDLE.
- Echo already high on TRIG entry (stale echo): ignored; WAIT_ECHO only leaves on rising edge of sync echo.
- Echo on non-selected channels: ignored.
- enable drop mid-measurement: current measurement completes and reports normally; then IDLE. Pointer keeps advanced value.
- distance, dist_ch, timeout hold until next REPORT.
- Measurement with echo exactly MAX_ECHO_US: echo fall on same cycle as limit counts as valid (fall has priority).

Optional Feature:
Macro ULTRASONIC_AVG_EN. Defined: per-channel register array; reported distance = (3*prev + new)/4 (shift-based, truncating) for that channel; first valid sample after reset loads directly; timeout samples pass all-ones through and do not update the average. Undefined: raw mm value reported, no array instantiated.

Test Plan:
- Sim params CLK_HZ=1000000, NUM_CH=2 (CYC_US=1, CYC_PER_MM=6): reset=0 5 cycles -> all outputs 0, trigger=0.
- enable=1, ch0 echo high 600 cycles 100 cycles after trigger fall -> trigger[0] high exactly 10 cycles; valid pulse, distance=100, dist_ch=0, timeout=0.
- No echo on ch1 -> valid 30000 cycles after trigger fall with timeout=1, distance=16'hFFFF, dist_ch=1.
- Echo held high 26000 cycles -> REPORT at 25000 cycles, timeout=1, distance=16'hFFFF; next trigger[0] rise exactly 60000 cycles after previous.
- reset=0 during MEASURE -> trigger=0, valid never pulses, next trigger on ch0 after release.
- ULTRASONIC_AVG_EN defined: ch0 echoes giving 100 then 200 mm -> reported 100 then 125.
